// File: rtl/demux2_n_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux2_n_buf
// Description : Buffered 1-to-2 N-bit demultiplexer. One valid/ready input
//               stream is steered by in_sel to channel A (0) or channel B (1).
//               Each channel owns a 2-entry FIFO, so a stalled consumer on one
//               side never blocks, corrupts or reorders the other side.
//
// Ports       : clk                 rising-edge clock
//               reset               synchronous, active-high reset
//               in_data/in_sel      word to route and its destination
//               in_valid/in_ready   producer handshake (in_ready is decoded
//                                   from registered occupancy and in_sel only)
//               a_data/a_valid      head of FIFO A, FIFO A not empty
//               a_ready             consumer A accepts the head word
//               b_data/b_valid      head of FIFO B, FIFO B not empty
//               b_ready             consumer B accepts the head word
//               a_count/b_count     16-bit accepted-word counters per channel,
//                                   present only when DEMUX2_N_STATS_EN is
//                                   defined
//
// Options     : DEMUX2_N_STATS_EN   adds the a_count/b_count statistics ports
//
// Revision    : 1.0 - initial release
// ============================================================================

module demux2_n_buf #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,

    input  logic [N-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,

    output logic [N-1:0] a_data,
    output logic         a_valid,
    input  logic         a_ready,

    output logic [N-1:0] b_data,
    output logic         b_valid,
    input  logic         b_ready
`ifdef DEMUX2_N_STATS_EN
    ,
    output logic [15:0]  a_count,
    output logic [15:0]  b_count
`endif
);

    // Occupancy at which a FIFO refuses further pushes.
    localparam logic [1:0] c_depth = 2'd2;

    // Per-channel status/handshake vectors, index 0 = A, index 1 = B.
    logic [1:0]   w_full;
    logic [1:0]   w_valid;
    logic [1:0]   w_push;
    logic [1:0]   w_pop;
    logic [1:0]   w_out_ready;
    logic [N-1:0] w_head [2];
    logic         w_sel_full;
    logic         w_xfer;

    assign w_out_ready = {b_ready, a_ready};

    // in_ready looks only at registered occupancy of the selected channel.
    // A full FIFO whose consumer pops this cycle still reports full; the
    // freed slot is advertised one cycle later, which keeps consumer ready
    // signals out of the producer's combinational path.
    assign w_sel_full = in_sel ? w_full[1] : w_full[0];
    assign in_ready   = ~reset & ~w_sel_full;
    assign w_xfer     = in_valid & in_ready;

    assign w_push[0]  = w_xfer & ~in_sel;
    assign w_push[1]  = w_xfer &  in_sel;
    assign w_pop      = w_valid & w_out_ready;

    // ------------------------------------------------------------------------
    // Two identical 2-entry FIFOs. Full/empty comes from the occupancy count,
    // never from comparing the 1-bit pointers, since the pointers alias when
    // the FIFO is either empty or full.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [N-1:0] r_mem0;
            logic [N-1:0] r_mem1;
            logic [1:0]   r_cnt;
            logic         r_wp;
            logic         r_rp;

            always_ff @(posedge clk) begin
                if (reset) begin
                    // Storage is cleared so the data outputs read 0 after reset.
                    r_mem0 <= '0;
                    r_mem1 <= '0;
                    r_cnt  <= 2'd0;
                    r_wp   <= 1'b0;
                    r_rp   <= 1'b0;
                end else begin
                    if (w_push[gi]) begin
                        if (r_wp) begin
                            r_mem1 <= in_data;
                        end else begin
                            r_mem0 <= in_data;
                        end
                        r_wp <= ~r_wp;
                    end

                    if (w_pop[gi]) begin
                        r_rp <= ~r_rp;
                    end

                    // Push and pop together can only happen at count 1 (a
                    // full FIFO blocks the push, an empty one has no pop),
                    // and leave the count unchanged.
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            assign w_full[gi]  = (r_cnt == c_depth);
            assign w_valid[gi] = (r_cnt != 2'd0);
            assign w_head[gi]  = r_rp ? r_mem1 : r_mem0;
        end
    endgenerate

    assign a_data  = w_head[0];
    assign a_valid = w_valid[0];
    assign b_data  = w_head[1];
    assign b_valid = w_valid[1];

`ifdef DEMUX2_N_STATS_EN
    // ------------------------------------------------------------------------
    // Accepted-word counters; free-running and wrapping at 16 bits.
    // ------------------------------------------------------------------------
    logic [15:0] r_a_count;
    logic [15:0] r_b_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_count <= 16'd0;
            r_b_count <= 16'd0;
        end else begin
            if (w_push[0]) begin
                r_a_count <= r_a_count + 16'd1;
            end
            if (w_push[1]) begin
                r_b_count <= r_b_count + 16'd1;
            end
        end
    end

    assign a_count = r_a_count;
    assign b_count = r_b_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux2_n_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux2_n_buf
// Description : Self-checking bench for demux2_n_buf. A queue-based model of
//               the two 2-entry channels is compared against the DUT on every
//               falling edge; directed sequences add literal expectations.
//               The statistics checks are compiled when DEMUX2_N_STATS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_demux2_n_buf;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic [N-1:0] in_data;
    logic         in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
`ifdef DEMUX2_N_STATS_EN
    logic [15:0]  a_count;
    logic [15:0]  b_count;
`endif

    demux2_n_buf #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX2_N_STATS_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: each channel is a queue holding at most two words.
    // ------------------------------------------------------------------------
    logic [N-1:0] qa [$];
    logic [N-1:0] qb [$];

    always @(posedge clk) begin
        bit acc;
        bit popa;
        bit popb;
        if (reset) begin
            qa.delete();
            qb.delete();
        end else begin
            acc  = in_valid && (in_sel ? (qb.size() < 2) : (qa.size() < 2));
            popa = (qa.size() > 0) && a_ready;
            popb = (qb.size() > 0) && b_ready;
            if (popa) void'(qa.pop_front());
            if (popb) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
    end

    // Compare process: outputs are sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", in_ready,
                !reset && (in_sel ? (qb.size() != 2) : (qa.size() != 2)));
            chk("m_a_valid", a_valid, qa.size() != 0);
            chk("m_b_valid", b_valid, qb.size() != 0);
            if (qa.size() != 0) chk("m_a_data", a_data, qa[0]);
            if (qb.size() != 0) chk("m_b_data", b_data, qb[0]);
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sel, input logic [N-1:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;

        // Reset held for two edges.
        cyc();
        started = 1'b1;
        cyc();
        #1;
        chk("rst_a_valid", a_valid, 1'b0);
        chk("rst_b_valid", b_valid, 1'b0);
        chk("rst_a_data", a_data, 32'h0);
        chk("rst_b_data", b_data, 32'h0);
        chk("rst_in_ready", in_ready, 1'b0);

        // Stream one word to each channel.
        reset = 1'b0;
        push(1'b0, 32'h1111_1111);
        #1 chk("post_rst_in_ready", in_ready, 1'b1);
        cyc();
        push(1'b1, 32'h2222_2222);
        #1;
        chk("s_a_valid", a_valid, 1'b1);
        chk("s_a_data", a_data, 32'h1111_1111);
        chk("s_in_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("s_b_valid", b_valid, 1'b1);
        chk("s_b_data", b_data, 32'h2222_2222);
        chk("s_a_drained", a_valid, 1'b0);
        cyc();

        // Fill A with its consumer stalled.
        a_ready = 1'b0;
        push(1'b0, 32'hA0);
        #1 chk("f_rdy0", in_ready, 1'b1);
        cyc();
        push(1'b0, 32'hA1);
        #1;
        chk("f_rdy1", in_ready, 1'b1);
        chk("f_head0", a_data, 32'hA0);
        cyc();
        push(1'b0, 32'hA2);
        #1;
        chk("f_rdy2_blocked", in_ready, 1'b0);
        chk("f_head1", a_data, 32'hA0);

        // A full does not block B.
        push(1'b1, 32'hB5);
        #1 chk("x_b_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        in_sel   = 1'b0;
        #1;
        chk("x_b_data", b_data, 32'hB5);
        chk("x_b_valid", b_valid, 1'b1);

        // Drain A: full-and-popping still reports not ready this cycle.
        a_ready = 1'b1;
        #1;
        chk("d_full_pop_rdy", in_ready, 1'b0);
        chk("d_head_a0", a_data, 32'hA0);
        cyc();
        #1;
        chk("d_head_a1", a_data, 32'hA1);
        chk("d_slot_freed", in_ready, 1'b1);
        cyc();
        #1 chk("d_a_empty", a_valid, 1'b0);

        // Concurrent push/pop at count 1.
        a_ready = 1'b0;
        push(1'b0, 32'h1);
        cyc();
        a_ready = 1'b1;
        push(1'b0, 32'h2);
        #1 chk("c_head1", a_data, 32'h1);
        cyc();
        push(1'b0, 32'h3);
        #1;
        chk("c_head2", a_data, 32'h2);
        chk("c_no_gap", a_valid, 1'b1);
        cyc();
        push(1'b0, 32'h4);
        #1 chk("c_head3", a_data, 32'h3);
        cyc();
        in_valid = 1'b0;
        #1 chk("c_head4", a_data, 32'h4);
        cyc();
        #1 chk("c_empty", a_valid, 1'b0);

        // Reset mid-operation: A holds two words, B one.
        a_ready = 1'b0;
        b_ready = 1'b0;
        push(1'b0, 32'h5);
        cyc();
        push(1'b0, 32'h6);
        cyc();
        push(1'b1, 32'h7);
        cyc();
        reset = 1'b1;
        push(1'b1, 32'h8);
        #1 chk("r_in_ready_low", in_ready, 1'b0);
        cyc();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("r_a_valid", a_valid, 1'b0);
        chk("r_b_valid", b_valid, 1'b0);
        chk("r_a_data", a_data, 32'h0);
        chk("r_b_data", b_data, 32'h0);
        push(1'b1, 32'h9);
        cyc();
        push(1'b1, 32'hC);
        #1 chk("r_b_head", b_data, 32'h9);
        cyc();
        push(1'b1, 32'hD);
        #1 chk("r_b_full_again", in_ready, 1'b0);
        in_valid = 1'b0;
        b_ready  = 1'b1;
        cyc();
        #1 chk("r_b_head2", b_data, 32'hC);
        cyc();
        cyc();

`ifdef DEMUX2_N_STATS_EN
        // 65537 accepted words to A wrap the counter to 1.
        reset = 1'b1;
        cyc();
        reset   = 1'b0;
        a_ready = 1'b1;
        push(1'b0, 32'h0);
        for (int i = 0; i < 65537; i++) begin
            in_data = i;
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("st_a_count", a_count, 16'd1);
        chk("st_b_count", b_count, 16'd0);
        cyc();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux2_n_buf.md
# demux2_n_buf

Buffered 1-to-2 n-bit demultiplexer: the steering counterpart to the 2-to-1 n-bit mux. It accepts one valid/ready input stream and routes each word to output channel A (in_sel=0) or B (in_sel=1). Each channel has its own 2-entry FIFO, so a stalled consumer on one side never corrupts or reorders traffic on the other. It sits between a single producer stage (e.g. the writeback result bus) and two independently stalling consumers.

## Interface
- n, default 32: data width in bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  n  word to route.
- in_sel  input  1  0 routes to A, 1 routes to B; sampled only with in_valid.
- in_valid  input  1  producer has a word.
- in_ready  output  1  selected channel can accept; transfer when in_valid & in_ready.
- a_data  output  n  head of FIFO A.
- a_valid  output  1  FIFO A not empty.
- a_ready  input  1  consumer A accepts; pop when a_valid & a_ready.
- b_data, b_valid, b_ready: same as A, for channel B.
- a_count, b_count  output  16 each  present only with DEMUX2_N_STATS_EN (see Configuration).

## Operation
- Two independent 2-entry FIFOs (A, B); each has a 2-bit occupancy (0..2), a write pointer and a read pointer.
- in_ready = ~reset & (in_sel ? (cnt_b != 2) : (cnt_a != 2)), decoded from registered occupancy only.
  - No combinational path from a_ready or b_ready to in_ready.
  - in_ready depends combinationally on in_sel.
- Push: on in_valid & in_ready, in_data is written at the selected FIFO's write pointer. The pointer toggles and the count increments, unless the same FIFO pops in the same cycle.
- Pop: on x_valid & x_ready, the read pointer toggles and the count decrements, unless the FIFO is also pushed in that cycle.
- Simultaneous push and pop on one FIFO:
  - Count unchanged.
  - Both pointers advance.
  - Legal only at count 1. At count 2 the push is blocked, so the count goes to 1. At count 0 there is no pop.
- A push to one channel and a pop from the other in the same cycle are fully independent.
- x_data = entry at the read pointer. x_data is held stable while x_valid & ~x_ready.
- Order is preserved within a channel. No ordering is defined across channels.
- No head-of-line blocking across channels: if A is full and B is not, a word with in_sel=1 is accepted.
- Reset:
  - Counts and pointers go to 0.
  - a_valid = b_valid = 0.
  - a_data = b_data = 0: storage is cleared to 0.
  - in_ready = 0 while reset is high.
  - Reset mid-transfer discards all buffered words; the handshake in the reset cycle does not complete.

## Timing
- Latency: a word accepted at edge k is visible on x_valid/x_data after edge k (cycle k+1). There is no same-cycle bypass.
- Throughput: 1 word/cycle per channel when that consumer holds ready high.
- After reset deasserts, in_ready = 1 in the first cycle.
- A FIFO at count 2 with its consumer popping gives in_ready = 0 that cycle. The freed slot is advertised in the next cycle.
- Wrap-around: the 1-bit pointers toggle 0→1→0. Full/empty is determined by count, never by pointer compare.

## Configuration
- DEMUX2_N_STATS_EN defined:
  - Adds ports a_count and b_count.
  - Each is a 16-bit counter of completed input transfers to that channel (increment on in_valid & in_ready & matching in_sel).
  - Wraps 0xFFFF→0x0000.
  - Reset to 0.
- DEMUX2_N_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset then stream: hold reset 2 cycles and check all outputs are 0. Then push 0x11111111 (sel 0) and 0x22222222 (sel 1) on consecutive cycles with both readies high. Required: A shows 0x11111111 one cycle after its accept, B shows 0x22222222 one cycle after its accept, and in_ready stays 1 throughout.
- Fill A: a_ready=0, push 0xA0, 0xA1, 0xA2 with sel 0. Required:
  - 0xA0 and 0xA1 are accepted.
  - in_ready=0 on the third push.
  - a_data holds 0xA0.
  - Raising a_ready pops 0xA0 then 0xA1, and in_ready returns one cycle after the first pop.
- No cross-blocking: with A full (a_ready=0), push 0xB5 with sel 1. Required: accepted immediately, and b_data=0xB5 on the next cycle.
- Concurrent push/pop at count 1: A holds 0x1 and a_ready=1, push 0x2 to A. Required: count stays 1, and a_data goes 0x1→0x2 with no gap; then push 0x3 and 0x4 and check order 0x2, 0x3, 0x4.
- Reset mid-operation: with A=2 entries and B=1 entry, assert reset for 1 cycle with in_valid high. Required: a_valid=b_valid=0 after the edge, the word offered during reset is not stored, and the counts restart from 0.
- With DEMUX2_N_STATS_EN defined: 65537 transfers to A. Required: a_count=1 and b_count=0.
